// File: rtl/core_pkg.sv
// core_pkg: shared issue-queue constants and wakeup-bus field helper
package core_pkg;
    localparam int TAG_W = 6;
    localparam int ISSUE_ENTRIES = 16;
    localparam int WAKE_BUS_W = 64;

    function automatic logic [WAKE_BUS_W-1:0] wake_field(input logic [WAKE_BUS_W-1:0] bus, input int p, input int w);
        return (bus >> (p * w)) & ((WAKE_BUS_W'(1) << w) - WAKE_BUS_W'(1));
    endfunction
endpackage

// File: rtl/agemat.sv
// agemat: age matrix picking the oldest (or youngest) requester
module agemat #(
    parameter int WIDTH = 16,
    parameter bit OLDEST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             insert_valid,
    input  logic [WIDTH-1:0] insert_sel,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid
);
    logic [WIDTH-1:0] older [WIDTH];

    // new slot becomes younger than every other slot: clear its row, set its column
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++)
            older[i] <= rst ? '0 : !insert_valid ? older[i] : insert_sel[i] ? '0 : older[i] | insert_sel;
    end

    // a requester wins when no other requester outranks it
    always_comb begin
        grant = '0;
        for (int i = 0; i < WIDTH; i++) begin
            grant[i] = req[i];
            for (int j = 0; j < WIDTH; j++)
                if (req[j] && (OLDEST ? older[j][i] : older[i][j])) grant[i] = 1'b0;
        end
    end

    assign grant_valid = |req;
endmodule

// File: rtl/issue_queue.sv
// issue_queue: out-of-order issue queue with tag wakeup and oldest-first select
module issue_queue #(
    parameter int ENTRIES = core_pkg::ISSUE_ENTRIES,
    parameter int TAG_W = core_pkg::TAG_W,
    parameter int PAYLOAD_W = 32,
    parameter int WAKE_PORTS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [PAYLOAD_W-1:0]        disp_payload,
    input  logic [TAG_W-1:0]            disp_src1_tag,
    input  logic [TAG_W-1:0]            disp_src2_tag,
    input  logic                        disp_src1_rdy,
    input  logic                        disp_src2_rdy,
    input  logic [WAKE_PORTS-1:0]       wake_valid,
    input  logic [WAKE_PORTS*TAG_W-1:0] wake_tag,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [PAYLOAD_W-1:0]        iss_payload,
    output logic [$clog2(ENTRIES):0]    count
);
    import core_pkg::*;
    localparam int CW = $clog2(ENTRIES) + 1;

    logic [ENTRIES-1:0] valid, src1_rdy, src2_rdy, req, grant, alloc, wake1, wake2;
    logic [TAG_W-1:0] src1_tag [ENTRIES];
    logic [TAG_W-1:0] src2_tag [ENTRIES];
    logic [PAYLOAD_W-1:0] payload [ENTRIES];
    logic grant_valid, disp_fire, iss_fire, disp_wake1, disp_wake2;
    logic [WAKE_BUS_W-1:0] wbus;

    function automatic logic woken(input logic [WAKE_PORTS-1:0] v, input logic [WAKE_BUS_W-1:0] bus, input logic [TAG_W-1:0] tag);
        logic hit = 1'b0;
        for (int p = 0; p < WAKE_PORTS; p++)
            hit |= v[p] && (wake_field(bus, p, TAG_W) == WAKE_BUS_W'(tag));
        return hit;
    endfunction

    assign wbus = WAKE_BUS_W'(wake_tag);
    assign alloc = ~valid & (valid + ENTRIES'(1));
    assign req = valid & src1_rdy & src2_rdy;
    assign disp_ready = count != CW'(ENTRIES);
    assign disp_fire = disp_valid & disp_ready;
    assign iss_valid = grant_valid & ~flush;
    assign iss_fire = iss_valid & iss_ready;

    agemat #(.WIDTH(ENTRIES), .OLDEST(1)) u_agemat (
        .clk(clk),
        .rst(rst),
        .insert_valid(disp_fire & ~flush),
        .insert_sel(alloc),
        .req(req),
        .grant(grant),
        .grant_valid(grant_valid)
    );

    // tag matches against the wakeup bus and the granted payload mux
    always_comb begin
        iss_payload = '0;
        disp_wake1 = woken(wake_valid, wbus, disp_src1_tag);
        disp_wake2 = woken(wake_valid, wbus, disp_src2_tag);
        for (int i = 0; i < ENTRIES; i++) begin
            wake1[i] = woken(wake_valid, wbus, src1_tag[i]);
            wake2[i] = woken(wake_valid, wbus, src2_tag[i]);
            if (grant[i]) iss_payload = payload[i];
        end
    end

    // occupancy: flush and reset empty the queue, issue frees, dispatch fills
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
            count <= '0;
        end else begin
            valid <= (valid & ~(iss_fire ? grant : '0)) | (disp_fire ? alloc : '0);
            count <= count + CW'(disp_fire) - CW'(iss_fire);
        end
    end

    // per-slot operands: capture on dispatch, otherwise accumulate wakeups
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            src1_rdy[i] <= (disp_fire && alloc[i]) ? (disp_src1_rdy | disp_wake1) : (src1_rdy[i] | wake1[i]);
            src2_rdy[i] <= (disp_fire && alloc[i]) ? (disp_src2_rdy | disp_wake2) : (src2_rdy[i] | wake2[i]);
            if (disp_fire && alloc[i]) begin
                src1_tag[i] <= disp_src1_tag;
                src2_tag[i] <= disp_src2_tag;
                payload[i] <= disp_payload;
            end
        end
    end
endmodule
